// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter and its return stack.
// Holds clog2, the strobe-decode op enum and the return-stack state enum.
package pc_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_REL,
    OP_LOAD,
    OP_RET,
    OP_CALL
  } pc_op_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } stk_st_t;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return stack, DEPTH x AW, with occupancy and EMPTY/PARTIAL/FULL state.
// Ports: clock, rst, push, pop, wdata -> rdata (top entry), depth, full, empty.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AW-1:0]        wdata,
  output logic [AW-1:0]        rdata,
  output logic [clog2(DEPTH):0] depth,
  output logic                 full,
  output logic                 empty
);

  localparam int DW = clog2(DEPTH) + 1;
  localparam int IW = DW - 1;

  logic [AW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_depth;
  logic [DW-1:0] w_depth_nxt;
  stk_st_t       r_st;
  stk_st_t       w_st_nxt;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push && (r_st != ST_FULL);
  assign w_do_pop  = pop && !push && (r_st != ST_EMPTY);

  // at depth==DEPTH the low bits wrap to 0, so top is DEPTH-1
  assign w_wr_idx = r_depth[IW-1:0];
  assign w_rd_idx = r_depth[IW-1:0] - IW'(1);

  assign rdata = r_mem[w_rd_idx];
  assign depth = r_depth;
  assign full  = (r_st == ST_FULL);
  assign empty = (r_st == ST_EMPTY);

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[w_wr_idx] <= wdata;
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_depth_nxt = r_depth;
    if (w_do_push)
      w_depth_nxt = r_depth + DW'(1);
    else if (w_do_pop)
      w_depth_nxt = r_depth - DW'(1);
    unique case (r_st)
      ST_EMPTY:
        if (w_do_push) w_st_nxt = ST_PARTIAL;
      ST_PARTIAL:
        if (w_do_push && r_depth == DW'(DEPTH - 1))
          w_st_nxt = ST_FULL;
        else if (w_do_pop && r_depth == DW'(1))
          w_st_nxt = ST_EMPTY;
      ST_FULL:
        if (w_do_pop) w_st_nxt = ST_PARTIAL;
      default: w_st_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_st    <= ST_EMPTY;
      r_depth <= '0;
    end else begin
      r_st    <= w_st_nxt;
      r_depth <= w_depth_nxt;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Fetch-stage PC: inc/rel/load/call/ret with hardware return stack, sticky ovf/unf.
// Ports: clock, rst, in, strobes -> out, depth, ovf, unf; PC_BRANCH_TRACE_EN adds last_src/last_vld.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int              AW        = 16,
  parameter int unsigned     STEP      = 1,
  parameter int              DEPTH     = 8,
  parameter logic [AW-1:0]   RESET_VEC = '0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [AW-1:0]         in,
  input  logic                  load,
  input  logic                  inc,
  input  logic                  rel,
  input  logic                  call,
  input  logic                  ret,
  output logic [AW-1:0]         out,
  output logic [clog2(DEPTH):0] depth,
  output logic                  ovf,
  output logic                  unf
`ifdef PC_BRANCH_TRACE_EN
  ,
  output logic [AW-1:0]         last_src,
  output logic                  last_vld
`endif
);

  localparam logic [AW-1:0] STEP_V = AW'(STEP);

  pc_op_t        w_op;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_top;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          r_ovf;
  logic          r_unf;

  // several strobes may be high at once; first match wins
  always_comb begin
    w_op = OP_HOLD;
    priority case (1'b1)
      call:    w_op = OP_CALL;
      ret:     w_op = OP_RET;
      load:    w_op = OP_LOAD;
      rel:     w_op = OP_REL;
      inc:     w_op = OP_INC;
      default: w_op = OP_HOLD;
    endcase
  end

  assign w_push = (w_op == OP_CALL) && !w_full;
  assign w_pop  = (w_op == OP_RET) && !w_empty;

  always_comb begin
    w_pc_nxt = r_pc;
    unique case (w_op)
      OP_INC:  w_pc_nxt = r_pc + STEP_V;
      OP_REL:  w_pc_nxt = r_pc + in;
      OP_LOAD: w_pc_nxt = in;
      OP_CALL: w_pc_nxt = in;
      // return on empty degrades to a plain increment
      OP_RET:  w_pc_nxt = w_empty ? r_pc + STEP_V : w_top;
      default: w_pc_nxt = r_pc;
    endcase
  end

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock (clock),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (r_pc + STEP_V),
    .rdata (w_top),
    .depth (depth),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_pc  <= RESET_VEC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_op == OP_CALL && w_full) r_ovf <= 1'b1;
      if (w_op == OP_RET && w_empty) r_unf <= 1'b1;
    end
  end

  assign out = r_pc;
  assign ovf = r_ovf;
  assign unf = r_unf;

`ifdef PC_BRANCH_TRACE_EN
  logic          w_taken;
  logic [AW-1:0] r_src;
  logic          r_vld;

  assign w_taken = (w_op == OP_LOAD) || (w_op == OP_REL) ||
                   (w_op == OP_CALL) || w_pop;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_src <= '0;
      r_vld <= 1'b0;
    end else if (w_taken) begin
      r_src <= r_pc;
      r_vld <= 1'b1;
    end
  end

  assign last_src = r_src;
  assign last_vld = r_vld;
`endif

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios then random strobes
// against a queue-based reference model.
module tb_pc_call_stack;
  import pc_pkg::*;

  localparam int            AW     = 16;
  localparam int unsigned   STEP   = 1;
  localparam int            DEPTH  = 4;
  localparam int            DW     = clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RV     = 16'h0000;
  localparam logic [AW-1:0] STEP_V = 16'h0001;

  // strobe vector order: {call, ret, load, rel, inc}
  localparam logic [4:0] S_C = 5'b10000;
  localparam logic [4:0] S_R = 5'b01000;
  localparam logic [4:0] S_L = 5'b00100;
  localparam logic [4:0] S_B = 5'b00010;
  localparam logic [4:0] S_I = 5'b00001;

  logic          clock = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] in = '0;
  logic          load = 1'b0;
  logic          inc = 1'b0;
  logic          rel = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [AW-1:0] out;
  logic [DW-1:0] depth;
  logic          ovf;
  logic          unf;
`ifdef PC_BRANCH_TRACE_EN
  logic [AW-1:0] last_src;
  logic          last_vld;
  logic [AW-1:0] m_src;
  logic          m_vld;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk[$];
  logic          m_ovf;
  logic          m_unf;

  pc_call_stack #(
    .AW        (AW),
    .STEP      (STEP),
    .DEPTH     (DEPTH),
    .RESET_VEC (RV)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .in    (in),
    .load  (load),
    .inc   (inc),
    .rel   (rel),
    .call  (call),
    .ret   (ret),
    .out   (out),
    .depth (depth),
    .ovf   (ovf),
    .unf   (unf)
`ifdef PC_BRANCH_TRACE_EN
    ,
    .last_src (last_src),
    .last_vld (last_vld)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_pc = RV;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
`ifdef PC_BRANCH_TRACE_EN
    m_src = '0;
    m_vld = 1'b0;
`endif
  endtask

  task automatic model_trace();
`ifdef PC_BRANCH_TRACE_EN
    m_src = m_pc;
    m_vld = 1'b1;
`endif
  endtask

  task automatic model_step();
    pc_op_t op;
    op = OP_HOLD;
    if (call)      op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (load) op = OP_LOAD;
    else if (rel)  op = OP_REL;
    else if (inc)  op = OP_INC;
    case (op)
      OP_CALL: begin
        model_trace();
        if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + STEP_V);
        else m_ovf = 1'b1;
        m_pc = in;
      end
      OP_RET: begin
        if (m_stk.size() > 0) begin
          model_trace();
          m_pc = m_stk.pop_back();
        end else begin
          m_unf = 1'b1;
          m_pc = m_pc + STEP_V;
        end
      end
      OP_LOAD: begin
        model_trace();
        m_pc = in;
      end
      OP_REL: begin
        model_trace();
        m_pc = m_pc + in;
      end
      OP_INC: m_pc = m_pc + STEP_V;
      default: ;
    endcase
  endtask

  // drive at negedge, capture at posedge, return at next negedge
  task automatic cyc(input logic [4:0] s, input logic [AW-1:0] d);
    {call, ret, load, rel, inc} = s;
    in = d;
    @(posedge clock);
    model_step();
    @(negedge clock);
    {call, ret, load, rel, inc} = 5'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (out !== RV) begin
      errors++;
      $display("FAIL reset_out got=%h exp=%h", out, RV);
    end
    checks++;
    if (depth !== 3'd0) begin
      errors++;
      $display("FAIL reset_depth got=%0d exp=0", depth);
    end
    checks++;
    if ({ovf, unf} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00", {ovf, unf});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_inc_load();
    logic [AW-1:0] eo [6] = '{16'h0001, 16'h0002, 16'h0003,
                              16'hFFFE, 16'hFFFF, 16'h0000};
    for (int k = 0; k < 6; k++) begin
      if (k == 3) cyc(S_L, 16'hFFFE);
      else cyc(S_I, 16'h5A5A);
      checks++;
      if (out !== eo[k]) begin
        errors++;
        $display("FAIL inc_load[%0d] got=%h exp=%h", k, out, eo[k]);
      end
    end
  endtask

  task automatic test_rel();
    logic [4:0]    st [3] = '{S_L, S_B, S_B};
    logic [AW-1:0] di [3] = '{16'h0100, 16'hFFFC, 16'h0010};
    logic [AW-1:0] eo [3] = '{16'h0100, 16'h00FC, 16'h010C};
    for (int k = 0; k < 3; k++) begin
      cyc(st[k], di[k]);
      checks++;
      if (out !== eo[k]) begin
        errors++;
        $display("FAIL rel[%0d] got=%h exp=%h", k, out, eo[k]);
      end
    end
  endtask

  task automatic test_nested_call();
    logic [4:0]    st [10] = '{S_L, S_C, S_C, S_C, S_C, S_C,
                               S_R, S_R, S_R, S_R};
    logic [AW-1:0] di [10] = '{16'h0010, 16'h0200, 16'h0300, 16'h0400,
                               16'h0500, 16'h0600, 16'h0, 16'h0,
                               16'h0, 16'h0};
    logic [AW-1:0] eo [10] = '{16'h0010, 16'h0200, 16'h0300, 16'h0400,
                               16'h0500, 16'h0600, 16'h0401, 16'h0301,
                               16'h0201, 16'h0011};
    logic [2:0]    ed [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4,
                               3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 10; k++) begin
      cyc(st[k], di[k]);
      checks++;
      if (out !== eo[k] || depth !== ed[k]) begin
        errors++;
        $display("FAIL nested[%0d] got=%h/%0d exp=%h/%0d",
                 k, out, depth, eo[k], ed[k]);
      end
      if (k == 4) begin
        checks++;
        if (ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got=%b exp=0", ovf);
        end
      end
    end
    checks++;
    if ({ovf, unf} !== 2'b10) begin
      errors++;
      $display("FAIL nested_flags got=%b exp=10", {ovf, unf});
    end
  endtask

  task automatic test_empty_ret();
    cyc(S_L, 16'h0050);
    cyc(S_R, 16'h0000);
    checks++;
    if (out !== 16'h0051 || depth !== 3'd0 || unf !== 1'b1) begin
      errors++;
      $display("FAIL empty_ret got=%h/%0d/%b exp=0051/0/1",
               out, depth, unf);
    end
    cyc(S_I, 16'h0000);
    checks++;
    if (out !== 16'h0052 || unf !== 1'b1) begin
      errors++;
      $display("FAIL unf_sticky got=%h/%b exp=0052/1", out, unf);
    end
  endtask

  task automatic test_simultaneous();
    cyc(S_L, 16'h0020);
    cyc(S_C | S_R | S_I, 16'h0700);
    checks++;
    if (out !== 16'h0700 || depth !== 3'd1) begin
      errors++;
      $display("FAIL call_ret_inc got=%h/%0d exp=0700/1", out, depth);
    end
    cyc(S_R, 16'h0000);
    checks++;
    if (out !== 16'h0021 || depth !== 3'd0) begin
      errors++;
      $display("FAIL top_check got=%h/%0d exp=0021/0", out, depth);
    end
    cyc(S_L | S_I, 16'h1234);
    checks++;
    if (out !== 16'h1234) begin
      errors++;
      $display("FAIL load_inc got=%h exp=1234", out);
    end
    cyc(S_B | S_I, 16'h0010);
    checks++;
    if (out !== 16'h1244) begin
      errors++;
      $display("FAIL rel_inc got=%h exp=1244", out);
    end
  endtask

  task automatic test_async_reset();
    cyc(S_C, 16'h0100);
    cyc(S_C, 16'h0200);
    cyc(S_C, 16'h0300);
    checks++;
    if (depth !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_depth got=%0d exp=3", depth);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out !== RV || depth !== 3'd0 || {ovf, unf} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset got=%h/%0d/%b exp=%h/0/00",
               out, depth, {ovf, unf}, RV);
    end
`ifdef PC_BRANCH_TRACE_EN
    checks++;
    if (last_vld !== 1'b0 || last_src !== '0) begin
      errors++;
      $display("FAIL reset_trace got=%b/%h exp=0/0000",
               last_vld, last_src);
    end
`endif
    model_reset();
    @(negedge clock);
    rst = 1'b0;
    cyc(S_R, 16'h0000);
    checks++;
    if (out !== RV + STEP_V || unf !== 1'b1) begin
      errors++;
      $display("FAIL ret_after_reset got=%h/%b exp=%h/1",
               out, unf, RV + STEP_V);
    end
  endtask

  task automatic test_random();
    logic [4:0]    s;
    logic [AW-1:0] d;
    for (int k = 0; k < 400; k++) begin
      if (k % 100 == 99) begin
        #2 rst = 1'b1;
        model_reset();
        @(negedge clock);
        rst = 1'b0;
      end
      s[4] = ($urandom_range(0, 2) == 0);
      s[3] = ($urandom_range(0, 2) == 0);
      s[2] = ($urandom_range(0, 5) == 0);
      s[1] = ($urandom_range(0, 5) == 0);
      s[0] = ($urandom_range(0, 1) == 0);
      d = AW'($urandom);
      cyc(s, d);
      checks++;
      if (out !== m_pc) begin
        errors++;
        $display("FAIL rnd_out[%0d] got=%h exp=%h", k, out, m_pc);
      end
      checks++;
      if (depth !== DW'(m_stk.size())) begin
        errors++;
        $display("FAIL rnd_depth[%0d] got=%0d exp=%0d",
                 k, depth, m_stk.size());
      end
      checks++;
      if ({ovf, unf} !== {m_ovf, m_unf}) begin
        errors++;
        $display("FAIL rnd_flags[%0d] got=%b exp=%b",
                 k, {ovf, unf}, {m_ovf, m_unf});
      end
`ifdef PC_BRANCH_TRACE_EN
      checks++;
      if (last_vld !== m_vld || last_src !== m_src) begin
        errors++;
        $display("FAIL rnd_trace[%0d] got=%b/%h exp=%b/%h",
                 k, last_vld, last_src, m_vld, m_src);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_inc_load();
    test_rel();
    test_nested_call();
    test_empty_ret();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised program counter, successor to the 16-bit load/increment PC.
- Adds configurable address width, configurable increment step, PC-relative branch, and a hardware call/return stack of configurable depth.
- Sits in the CPU fetch stage. It drives the instruction-memory address and takes control strobes from the decoder.

Parameters:
- AW, 16, address/PC width in bits (legal 4..32)
- STEP, 1, amount added on inc (legal 1..2^(AW-1))
- DEPTH, 8, return-stack entries (legal 2..64, power of two)
- RESET_VEC, 0, value of out after reset (AW bits)

Ports:
- clock  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in  in  AW  absolute target for load/call, or signed offset for rel
- load  in  1  absolute jump: out <= in
- inc  in  1  sequential advance: out <= out + STEP
- rel  in  1  relative branch: out <= out + in (two's-complement)
- call  in  1  push out+STEP, then out <= in
- ret  in  1  pop: out <= top of stack
- out  out  AW  current PC
- depth  out  clog2(DEPTH)+1  stack occupancy 0..DEPTH
- ovf  out  1  sticky: call attempted while stack full
- unf  out  1  sticky: ret attempted while stack empty

Behaviour:
- Reset (async, active-high): out=RESET_VEC, depth=0, ovf=0, unf=0. Stack contents are don't-care. Deassertion is synchronous to clock in the surrounding design.
- All updates occur on the rising edge of clock. There is no combinational path from inputs to out.
- Priority when several strobes are high, highest first: call > ret > load > rel > inc. Lower-priority strobes in that cycle are ignored.
- No strobe high: out holds.
- Arithmetic is modulo 2^AW; wrap-around is silent.
  - out = 2^AW-STEP with inc gives out = 0.
  - rel with in = all-ones gives out-1.
- call, not full: stack[depth] <= out+STEP (mod 2^AW); depth+1; out <= in. All take effect in the same cycle.
- call, full (depth==DEPTH): out <= in; push discarded; depth unchanged; ovf <= 1.
- ret, not empty: out <= stack[depth-1]; depth-1. The value is visible on out the cycle after the edge.
- ret, empty: out <= out+STEP (behaves as inc); depth stays 0; unf <= 1.
- call and ret in the same cycle: call wins. No pop happens.
- ovf and unf stay set until rst.
- Return-stack internal state machine: EMPTY (depth=0), PARTIAL, FULL (depth=DEPTH). Transitions:
  - EMPTY -> PARTIAL on call.
  - PARTIAL -> FULL on call at depth DEPTH-1.
  - FULL -> PARTIAL on ret.
  - PARTIAL -> EMPTY on ret at depth 1.
- Reset in mid-sequence abandons all stack entries; depth returns to 0.

Optional Feature:
- Macro: PC_BRANCH_TRACE_EN.
- Defined:
  - Adds output last_src [AW] and output last_vld [1].
  - On every accepted load/rel/call/ret, last_src <= out value before the edge, and last_vld <= 1.
  - Both reset to 0.
  - Plain inc, and ret-on-empty, do not update them.
- Undefined: the ports are absent and no trace registers are built. All other behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - localparam function clog2
  - enum pc_op_t {OP_HOLD, OP_INC, OP_REL, OP_LOAD, OP_RET, OP_CALL}, used by the priority encoder and the testbench scoreboard
  - stack state enum {ST_EMPTY, ST_PARTIAL, ST_FULL}
- Sub-module pc_ret_stack: LIFO of DEPTH x AW.
  - Inputs: push, pop, wdata.
  - Outputs: rdata, depth, full, empty.
  - It does not manage the flags; pc_call_stack owns ovf/unf and the PC register.

Test Plan:
- AW=16, STEP=1: rst -> out=0000. inc for 3 cycles -> 0001, 0002, 0003. load in=FFFE, then inc twice -> FFFE, FFFF, 0000 (wrap).
- rel: out=0100, in=FFFC -> out=00FC. Then in=0010 -> out=010C.
- Nested calls at DEPTH=2, out=0010:
  - call in=0200 -> out=0200, depth=1.
  - call in=0300 -> out=0300, depth=2.
  - call in=0400 -> out=0400, depth=2, ovf=1.
  - ret -> 0201, ret -> 0011, depth=0.
- Empty ret: depth=0, out=0050, ret -> out=0051, unf=1. A subsequent inc keeps unf=1.
- Simultaneous strobes: call+ret+inc with out=0020, in=0700 -> out=0700, depth+1, top=0021. load+inc with in=1234 -> out=1234.
- Async reset mid-call sequence at depth=3: assert rst between edges -> out=RESET_VEC immediately, depth=0, ovf=unf=0. With PC_BRANCH_TRACE_EN, last_vld=0.
